mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single sram-like memory port (toward the AXI bridge) between the icache refill path and the dcache read/write path.
- Sits between the i/d caches and the AXI bridge; replaces ad-hoc inst/data sequencing with one owner-tracked transaction at a time.
- Priority is dcache > icache, with a starvation guard for icache.
- Flush drops icache traffic without corrupting the memory port.

Parameters:
- LEN_W, 4, width of burst length field (beats-1).
- STARVE_LIMIT, 4, consecutive icache losses after which icache wins the next arbitration.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- flush  in  1  pipeline flush; cancels icache traffic.
- i_req  in  1  icache read request, held until i_addr_ok.
- i_addr  in  32  icache physical address.
- i_len  in  LEN_W  icache burst beats-1.
- i_addr_ok  out  1  icache request accepted.
- i_data_ok  out  1  icache read beat valid on rdata.
- i_last  out  1  final icache beat.
- d_req  in  1  dcache request, held until d_addr_ok.
- d_wr  in  1  1 = write (single beat), 0 = read.
- d_addr  in  32  dcache physical address.
- d_len  in  LEN_W  dcache read beats-1; ignored for writes (forced 0).
- d_wstrb  in  4  byte strobes for writes.
- d_wdata  in  32  write data.
- d_addr_ok  out  1  dcache request accepted.
- d_data_ok  out  1  dcache read beat valid, or write response.
- d_last  out  1  final dcache beat.
- rdata  out  32  shared read data (mem_rdata forwarded).
- mem_req  out  1  request to bridge.
- mem_wr  out  1  write flag.
- mem_addr  out  32  address.
- mem_len  out  LEN_W  beats-1.
- mem_wstrb  out  4  strobes, 0 for reads.
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  bridge accepted request.
- mem_data_ok  in  1  bridge beat/response.
- mem_rdata  in  32  bridge read data.
- mem_last  in  1  bridge last-beat flag.
- busy  out  1  transaction in progress (state != IDLE).
- proto_err  out  1  sticky; set when mem_last disagrees with the beat count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; owner NONE; beat counter 0; starve counter 0.
  - All mem_* outputs, *_addr_ok, *_data_ok, *_last, busy and proto_err are 0.
  - Registered request fields are 0.
  - Reset mid-transaction abandons it; the bridge is reset by the same rst.
- States: IDLE, REQ, DATA, DRAIN.
- IDLE:
  - Arbitrate on d_req and (i_req & ~flush).
  - Winner order: icache if starve_cnt == STARVE_LIMIT and i_req; else dcache; else icache.
  - On a grant, register addr/len/wr/wstrb/wdata/owner and go to REQ.
  - mem_req is high from the next cycle (1-cycle grant latency).
- Starve counter:
  - Increments when dcache wins while i_req is pending; saturates at STARVE_LIMIT.
  - Clears when icache wins.
- REQ:
  - mem_req held high with stable fields until mem_addr_ok; never withdrawn.
  - owner's *_addr_ok = mem_addr_ok (combinational, same cycle).
  - On accept: go to DATA, beat counter = 0.
  - If owner = I and flush was seen during REQ or in this cycle, go to DRAIN instead, and i_addr_ok is suppressed.
- DATA:
  - Each mem_data_ok drives the owner's *_data_ok (combinational) and increments the beat counter.
  - Last beat is counter == len; this drives *_last.
  - On the last beat, go to IDLE next cycle, so back-to-back grants have a 1-cycle gap.
  - A write completes on its single mem_data_ok.
  - flush while owner = I: go to DRAIN; i_data_ok is suppressed from that same cycle.
  - flush has no effect on dcache transactions.
- DRAIN:
  - Consume the remaining beats silently (no *_data_ok).
  - Return to IDLE after the counted last beat.
- Error and data rules:
  - proto_err sets if mem_data_ok & mem_last while counter != len, or if counter == len & ~mem_last.
  - Completion is always decided by the counter.
  - mem_data_ok in IDLE or REQ is ignored and sets proto_err.
  - rdata = mem_rdata unconditionally; consumers qualify it with data_ok.
- Simultaneous events:
  - i_req and d_req together: dcache wins unless the starve limit is reached.
  - flush together with i_req in IDLE: no grant.
  - Requesters must hold request fields stable until addr_ok; the arbiter samples them only at grant.

Decomposition:
- Shared package `defines.v`: state encodings (IDLE=2'd0, REQ=2'd1, DATA=2'd2, DRAIN=2'd3), owner codes (NONE/I/D), RST_ENABLE reuse replaced by active-low macro.
- Sub-module `mem_arb_pick`: combinational priority and starve selection, unit-testable alone.

Test Plan:
- i_req only, addr 0x1FC0_0000, len 3; bridge addr_ok after 2 cycles, 4 beats -> mem_req on cycle 1; i_addr_ok aligned with mem_addr_ok; 4 i_data_ok pulses, i_last on the 4th; IDLE after.
- d_req write at 0x0000_1000, strb 4'b0011, data 0xDEADBEEF, together with i_req -> dcache granted first (mem_wr=1, mem_len=0); icache granted after d_data_ok plus a 1-cycle gap.
- Continuous d_req reads with i_req held, STARVE_LIMIT=4 -> exactly 4 dcache grants, then an icache grant.
- flush on the 2nd beat of an icache len-7 burst -> i_data_ok low from that cycle; remaining 6 beats drained; busy drops after the 8th beat.
- mem_last asserted on beat 2 of a len-3 read -> proto_err=1 and sticky; transaction still ends after beat 4.
- rst pulled low mid-DATA, asynchronously -> all outputs 0 immediately; after release, a new i_req is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transaction owner codes.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between dcache and icache, with the icache starvation guard.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             d_req_i,
    input  logic             i_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             gnt_i_o,
    output logic             gnt_d_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    logic starve_hit;

    always_comb begin
        starve_hit   = (starve_cnt_i == CNT_W'(STARVE_LIMIT));
        gnt_i_o      = i_req_i & (starve_hit | ~d_req_i);
        gnt_d_o      = d_req_i & ~gnt_i_o;
        starve_cnt_o = starve_cnt_i;
        if (gnt_i_o) begin
            starve_cnt_o = '0;
        end else if (gnt_d_o && i_req_i && !starve_hit) begin
            starve_cnt_o = starve_cnt_i + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one sram-like memory port between icache refills and dcache accesses,
// one owner-tracked transaction at a time; flush silently drains icache traffic.
module mem_arbiter #(
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    output logic             i_last,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [LEN_W-1:0] d_len,
    input  logic [3:0]       d_wstrb,
    input  logic [31:0]      d_wdata,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    output logic             d_last,
    output logic [31:0]      rdata,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [LEN_W-1:0] mem_len,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_last,
    output logic             busy,
    output logic             proto_err
);

    import mem_arbiter_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e             state_q, state_d;
    owner_e             owner_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic               wr_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [LEN_W-1:0]   beat_q;
    logic [CNT_W-1:0]   starve_q;
    logic [CNT_W-1:0]   starve_d;
    logic               flush_seen_q;
    logic               proto_err_q;

    logic i_vld, gnt_i, gnt_d, grant;
    logic last_beat, beat, i_flushed;

    assign i_vld     = i_req & ~flush;
    assign grant     = (state_q == ST_IDLE) & (gnt_i | gnt_d);
    assign last_beat = (beat_q == len_q);
    assign beat      = mem_data_ok & ((state_q == ST_DATA) | (state_q == ST_DRAIN));
    assign i_flushed = (owner_q == OWN_I) & (flush_seen_q | flush);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .d_req_i      (d_req),
        .i_req_i      (i_vld),
        .starve_cnt_i (starve_q),
        .gnt_i_o      (gnt_i),
        .gnt_d_o      (gnt_d),
        .starve_cnt_o (starve_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion is always decided by the beat counter, never by mem_last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_i || gnt_d) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem_addr_ok) state_d = i_flushed ? ST_DRAIN : ST_DATA;
            end
            ST_DATA: begin
                if (mem_data_ok && last_beat)              state_d = ST_IDLE;
                else if (owner_q == OWN_I && flush)        state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_data_ok && last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state_q == ST_REQ);
        mem_wr    = mem_req & wr_q;
        mem_addr  = mem_req ? addr_q  : '0;
        mem_len   = mem_req ? len_q   : '0;
        mem_wstrb = mem_req ? wstrb_q : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        i_addr_ok = mem_req & mem_addr_ok & (owner_q == OWN_I) & ~(flush_seen_q | flush);
        d_addr_ok = mem_req & mem_addr_ok & (owner_q == OWN_D);
        i_data_ok = (state_q == ST_DATA) & mem_data_ok & (owner_q == OWN_I) & ~flush;
        d_data_ok = (state_q == ST_DATA) & mem_data_ok & (owner_q == OWN_D);
        i_last    = i_data_ok & last_beat;
        d_last    = d_data_ok & last_beat;
        busy      = (state_q != ST_IDLE);
        proto_err = proto_err_q;
        rdata     = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_NONE;
            addr_q       <= '0;
            len_q        <= '0;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            starve_q     <= '0;
            flush_seen_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            if (grant) begin
                owner_q      <= gnt_i ? OWN_I : OWN_D;
                addr_q       <= gnt_i ? i_addr : d_addr;
                len_q        <= gnt_i ? i_len : (d_wr ? '0 : d_len);
                wr_q         <= gnt_d & d_wr;
                wstrb_q      <= (gnt_d & d_wr) ? d_wstrb : '0;
                wdata_q      <= gnt_i ? '0 : d_wdata;
                starve_q     <= starve_d;
                flush_seen_q <= 1'b0;
            end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
                owner_q <= OWN_NONE;
            end
            if (state_q == ST_REQ && owner_q == OWN_I && flush) begin
                flush_seen_q <= 1'b1;
            end
            if (state_q == ST_REQ && mem_addr_ok) begin
                beat_q <= '0;
            end else if (beat) begin
                beat_q <= beat_q + LEN_W'(1);
            end
            // Stray beats, or mem_last disagreeing with the counted last beat, latch the error.
            if (mem_data_ok && (state_q == ST_IDLE || state_q == ST_REQ)) begin
                proto_err_q <= 1'b1;
            end else if (beat && (mem_last != last_beat)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule
